lot_access_arbiter: RTL

//   Serialises car_enter/car_exit events from LANES gate FSMs onto one up/down occupancy counter.

---
 rtl/lot_access_arbiter.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/lot_access_arbiter.sv
// Round-robin serialiser of per-lane enter/exit events onto a shared up/down occupancy counter,
// with capacity enforcement, per-lane timed gate drive and sticky error flags.
module lot_access_arbiter #(
   parameter int LANES       = 2,
   parameter int BITS        = 8,
   parameter int CAPACITY    = 200,
   parameter int GATE_CYCLES = 16,
   parameter int TBITS       = 5
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [LANES-1:0] enter_req,
   input  logic [LANES-1:0] exit_req,
   output logic             cnt_en,
   output logic             cnt_up,
   output logic [BITS-1:0]  occupancy,
   output logic             full,
   output logic             empty,
   output logic [LANES-1:0] gate_open,
   output logic [LANES-1:0] denied,
   output logic             overrun,
   output logic             underflow
);

   localparam int SRC = 2 * LANES;
   localparam int PW  = $clog2(SRC);
   localparam logic [BITS-1:0]  CAP_V  = BITS'(CAPACITY);
   localparam logic [TBITS-1:0] GATE_V = TBITS'(GATE_CYCLES);

   typedef enum logic {GATE_CLOSED = 1'b0, GATE_OPEN = 1'b1} gate_state_t;

   logic [SRC-1:0]   pending_r;
   logic [SRC-1:0]   pending_nxt_s;
   logic [SRC-1:0]   req_s;
   logic [SRC-1:0]   grant_vec_s;
   logic [PW-1:0]    ptr_r;
   logic [PW-1:0]    ptr_nxt_s;
   logic [PW-1:0]    grant_idx_s;
   logic             grant_valid_s;
   logic             grant_exit_s;
   int               grant_lane_s;
   int               rr_j_s;
   logic             overrun_hit_s;
   logic             underflow_hit_s;
   logic             count_s;
   logic             count_up_s;
   logic [BITS-1:0]  occ_nxt_s;
   logic [LANES-1:0] deny_s;
   logic [LANES-1:0] load_s;

   gate_state_t      gate_state_r   [LANES];
   gate_state_t      gate_state_nxt_s [LANES];
   logic [TBITS-1:0] gate_timer_r   [LANES];
   logic [TBITS-1:0] gate_timer_nxt_s [LANES];

   // Round-robin pick starting at ptr_r, plus pending/overrun bookkeeping for this cycle.
   always_comb begin
      grant_valid_s = 1'b0;
      grant_idx_s   = '0;
      rr_j_s        = 0;
      req_s         = '0;
      grant_vec_s   = '0;
      for (int i = 0; i < SRC; i++) begin
         rr_j_s = int'(ptr_r) + i;
         if (rr_j_s >= SRC) begin
            rr_j_s = rr_j_s - SRC;
         end else begin
            rr_j_s = rr_j_s;
         end
         if (!grant_valid_s && pending_r[rr_j_s]) begin
            grant_valid_s = 1'b1;
            grant_idx_s   = PW'(rr_j_s);
         end else begin
            grant_valid_s = grant_valid_s;
         end
      end
      for (int l = 0; l < LANES; l++) begin
         req_s[2*l]   = enter_req[l];
         req_s[2*l+1] = exit_req[l];
      end
      if (grant_valid_s) begin
         grant_vec_s[grant_idx_s] = 1'b1;
         ptr_nxt_s = (grant_idx_s == PW'(SRC - 1)) ? '0 : grant_idx_s + PW'(1);
      end else begin
         ptr_nxt_s = ptr_r;
      end
      // A pulse landing on the same cycle as its own grant re-arms the source without overrun.
      pending_nxt_s = (pending_r & ~grant_vec_s) | req_s;
      overrun_hit_s = |(req_s & pending_r & ~grant_vec_s);
   end

   // Effect of the granted source on occupancy, gates and error flags.
   always_comb begin
      grant_lane_s    = int'(grant_idx_s) / 2;
      grant_exit_s    = grant_idx_s[0];
      count_s         = 1'b0;
      count_up_s      = cnt_up;
      underflow_hit_s = 1'b0;
      deny_s          = '0;
      load_s          = '0;
      if (grant_valid_s) begin
         if (!grant_exit_s) begin
            if (occupancy < CAP_V) begin
               count_s    = 1'b1;
               count_up_s = 1'b1;
               load_s[grant_lane_s] = 1'b1;
            end else begin
               deny_s[grant_lane_s] = 1'b1;
            end
         end else begin
            if (occupancy != '0) begin
               count_s    = 1'b1;
               count_up_s = 1'b0;
               load_s[grant_lane_s] = 1'b1;
            end else begin
               underflow_hit_s = 1'b1;
            end
         end
      end else begin
         count_s = 1'b0;
      end
      if (count_s) begin
         occ_nxt_s = count_up_s ? occupancy + BITS'(1) : occupancy - BITS'(1);
      end else begin
         occ_nxt_s = occupancy;
      end
   end

   // Per-lane gate FSM: a grant (re)loads the timer, OPEN counts down to CLOSED.
   always_comb begin
      for (int l = 0; l < LANES; l++) begin
         gate_state_nxt_s[l] = gate_state_r[l];
         gate_timer_nxt_s[l] = gate_timer_r[l];
         case (gate_state_r[l])
            GATE_CLOSED: begin
               if (load_s[l]) begin
                  gate_state_nxt_s[l] = GATE_OPEN;
                  gate_timer_nxt_s[l] = GATE_V;
               end else begin
                  gate_timer_nxt_s[l] = '0;
               end
            end
            GATE_OPEN: begin
               if (load_s[l]) begin
                  gate_timer_nxt_s[l] = GATE_V;
               end else if (gate_timer_r[l] == TBITS'(1)) begin
                  gate_state_nxt_s[l] = GATE_CLOSED;
                  gate_timer_nxt_s[l] = '0;
               end else begin
                  gate_timer_nxt_s[l] = gate_timer_r[l] - TBITS'(1);
               end
            end
            default: begin
               gate_state_nxt_s[l] = GATE_CLOSED;
               gate_timer_nxt_s[l] = '0;
            end
         endcase
      end
   end

   // State and registered outputs; reset overrides everything else in the cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         pending_r <= '0;
         ptr_r     <= '0;
         cnt_en    <= 1'b0;
         cnt_up    <= 1'b0;
         occupancy <= '0;
         full      <= 1'b0;
         empty     <= 1'b1;
         gate_open <= '0;
         denied    <= '0;
         overrun   <= 1'b0;
         underflow <= 1'b0;
         for (int l = 0; l < LANES; l++) begin
            gate_state_r[l] <= GATE_CLOSED;
            gate_timer_r[l] <= '0;
         end
      end else begin
         pending_r <= pending_nxt_s;
         ptr_r     <= ptr_nxt_s;
         cnt_en    <= count_s;
         cnt_up    <= count_up_s;
         occupancy <= occ_nxt_s;
         full      <= (occ_nxt_s == CAP_V);
         empty     <= (occ_nxt_s == '0);
         denied    <= deny_s;
         overrun   <= overrun | overrun_hit_s;
         underflow <= underflow | underflow_hit_s;
         for (int l = 0; l < LANES; l++) begin
            gate_state_r[l] <= gate_state_nxt_s[l];
            gate_timer_r[l] <= gate_timer_nxt_s[l];
            gate_open[l]    <= (gate_state_nxt_s[l] == GATE_OPEN);
         end
      end
   end

endmodule
